// File: rtl/cpu1_pio_pkg.sv
// Shared definitions for the CPU1 PIO alarm output block.
// Holds the Avalon-MM register map and the auto-off countdown state encoding.
package cpu1_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Register word addresses
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_TIMER  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR = 2'd3;

    // Countdown states: IDLE holds count==0, RUN holds count>0
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/cpu1_autooff_timer.sv
// Auto-off countdown for the alarm output register.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   load          : load strobe (a TIMER register write)
//   load_val      : new countdown value; 0 cancels a running countdown
//   busy          : high while the countdown is nonzero
//   expire_c      : combinational pulse in the cycle whose edge takes count 1 -> 0
//   count         : current countdown value
module cpu1_autooff_timer
    import cpu1_pio_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             expire_c,
    output logic [CNT_W-1:0] count
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State and count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: a load always wins over the running decrement, so a reload
    // in the expiry cycle suppresses the expiry.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            count_d = load_val;
            state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy     = 1'b0;
        expire_c = 1'b0;
        if (state_q == ST_RUN) begin
            busy     = 1'b1;
            expire_c = (count_q == CNT_W'(1)) && !load;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu1_alarm_out.sv
// CPU1 alarm output PIO: Avalon-MM slave driving an output register with
// set/clear aliases and an auto-off countdown that clears the register on expiry.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM write side (no wait states)
//   readdata              : registered read data, updated every cycle
//   out_port              : data register to the pins
//   busy                  : countdown running
module cpu1_alarm_out
    import cpu1_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    logic             wr_en_c;
    logic             timer_load_c;
    logic             data_write_c;
    logic             expire_c;
    logic [WIDTH-1:0] wr_val_c;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_d;

    // Upper writedata bits are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en_c      = chipselect && !write_n;
    assign timer_load_c = wr_en_c && (address == ADDR_TIMER);
    assign data_write_c = wr_en_c && (address != ADDR_TIMER);
    assign wr_val_c     = WIDTH'(writedata);

    cpu1_autooff_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load_c),
        .load_val (CNT_W'(writedata)),
        .busy     (busy),
        .expire_c (expire_c),
        .count    (count)
    );

    // Data register update: any data-side write beats the auto-off clear
    always_comb begin
        data_d = data_q;
        if (data_write_c) begin
            case (address)
                ADDR_DATA:   data_d = wr_val_c;
                ADDR_OUTSET: data_d = data_q | wr_val_c;
                ADDR_OUTCLR: data_d = data_q & ~wr_val_c;
                default:     data_d = data_q;
            endcase
        end else if (expire_c) begin
            data_d = '0;
        end
    end

    // Read mux, registered below
    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA:  rd_d = DATA_W'(data_q);
            ADDR_TIMER: rd_d = DATA_W'(count);
            default:    rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= WIDTH'(RESET_VALUE);
            readdata <= '0;
        end else begin
            data_q   <= data_d;
            readdata <= rd_d;
        end
    end

    assign out_port = data_q;

endmodule

// File: tb/tb_cpu1_alarm_out.sv
// Directed self-checking bench for cpu1_alarm_out (WIDTH=8, CNT_W=16,
// RESET_VALUE=0x3C so the reset value is distinguishable from a clear).
module tb_cpu1_alarm_out;

    localparam logic [31:0] RV = 32'h0000_003C;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;

    int tests = 0;
    int fails = 0;

    cpu1_alarm_out #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One-cycle write; returns 1ns after the edge that performed it
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_port", 32'(out_port), RV);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        tick();
        check("rd_data_after_rst", readdata, RV);

        // DATA / OUTSET / OUTCLR, upper writedata bits ignored
        write_reg(2'd0, 32'hFFFF_FF5A);
        check("data_5a", 32'(out_port), 32'h5A);
        write_reg(2'd2, 32'h0000_0081);
        check("outset_db", 32'(out_port), 32'hDB);
        write_reg(2'd3, 32'hFFFF_FF0A);
        check("outclr_d1", 32'(out_port), 32'hD1);
        address = 2'd0;
        tick();
        check("rd_data_d1", readdata, 32'hD1);
        address = 2'd2;
        tick();
        check("rd_addr2_zero", readdata, 32'd0);
        address = 2'd3;
        tick();
        check("rd_addr3_zero", readdata, 32'd0);

        // Auto-off after 5 cycles
        write_reg(2'd0, 32'h0000_00FF);
        check("data_ff", 32'(out_port), 32'hFF);
        write_reg(2'd1, 32'h0000_0005);
        address = 2'd1;
        check("t5_busy_e0", 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t5_busy_run", 32'(busy), 32'd1);
            check("t5_out_hold", 32'(out_port), 32'hFF);
            if (i == 2) check("t5_rd_count4", readdata, 32'd4);
        end
        tick();
        check("t5_busy_off", 32'(busy), 32'd0);
        check("t5_out_cleared", 32'(out_port), 32'h00);
        tick();
        check("t5_rd_count0", readdata, 32'd0);

        // OUTSET on the expiry edge beats the clear
        write_reg(2'd0, 32'h0000_0030);
        write_reg(2'd1, 32'h0000_0003);
        tick();
        tick();
        write_reg(2'd2, 32'h0000_0004);
        check("exp_outset_out", 32'(out_port), 32'h34);
        check("exp_outset_busy", 32'(busy), 32'd0);
        tick();
        check("exp_outset_stays", 32'(out_port), 32'h34);

        // TIMER reload on the expiry edge: no clear, then clear later
        write_reg(2'd1, 32'h0000_0002);
        tick();
        write_reg(2'd1, 32'h0000_0002);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_no_clear", 32'(out_port), 32'h34);
        tick();
        check("reload_run_out", 32'(out_port), 32'h34);
        tick();
        check("reload_expire_out", 32'(out_port), 32'h00);
        check("reload_expire_busy", 32'(busy), 32'd0);

        // Cancel with TIMER=0
        write_reg(2'd0, 32'h0000_0066);
        write_reg(2'd1, 32'h0000_000A);
        tick();
        tick();
        tick();
        check("cancel_busy_before", 32'(busy), 32'd1);
        write_reg(2'd1, 32'h0000_0000);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_out", 32'(out_port), 32'h66);
        address = 2'd1;
        repeat (12) tick();
        check("cancel_out_later", 32'(out_port), 32'h66);
        check("cancel_busy_later", 32'(busy), 32'd0);
        check("cancel_rd_count", readdata, 32'd0);

        // Reset mid-countdown
        write_reg(2'd0, 32'h0000_00A5);
        write_reg(2'd1, 32'h0000_0008);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(out_port), RV);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) tick();
        check("midrst_no_clear", 32'(out_port), RV);
        check("midrst_busy_later", 32'(busy), 32'd0);

        // Write accepted on the first edge after reset release
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        write_reg(2'd0, 32'h0000_0011);
        check("first_edge_write", 32'(out_port), 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
